// File: rtl/ofs_fim_pcie_ss_rx_merge_if.sv
// AXI-S beat bundle shared by the CplD, request and merged RX streams.
interface ofs_fim_pcie_ss_rx_merge_if #(
   parameter int DATA_WIDTH = 512,
   parameter int TUSER_W    = 1
);
   logic                    tvalid;
   logic                    tready;
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [TUSER_W-1:0]      tuser;

   modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/ofs_fim_pcie_ss_rx_merge.sv
// Packet-atomic merge of the RX CplD and request streams into one registered
// stream; completions win up to CPLD_WEIGHT packets in a row while requests wait.
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no packet open, grant arbitrated this cycle
// LOCK_CPLD | CplD packet in flight, grant pinned to CplD
// LOCK_REQ  | request packet in flight, grant pinned to req
module ofs_fim_pcie_ss_rx_merge #(
   parameter int DATA_WIDTH  = 512,
   parameter int TUSER_W     = 1,
   parameter int CPLD_WEIGHT = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   ofs_fim_pcie_ss_rx_merge_if.slave         s_cpld,
   ofs_fim_pcie_ss_rx_merge_if.slave         s_req,
   ofs_fim_pcie_ss_rx_merge_if.master        m,
   output logic                              m_src
);
   localparam int              RUN_W   = $clog2(CPLD_WEIGHT + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPLD_WEIGHT);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOCK_CPLD = 2'd1,
      LOCK_REQ  = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [RUN_W-1:0]        cpld_run;
   logic                    load;
   logic                    grant_cpld;
   logic                    grant_req;
   logic                    accept_cpld;
   logic                    accept_req;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   beat_data;
   logic [DATA_WIDTH/8-1:0] beat_keep;
   logic                    beat_last;
   logic [TUSER_W-1:0]      beat_user;

   assign load = !m.tvalid || m.tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // IDLE arbitration is combinational so back-to-back packets see no bubble.
   always_comb begin
      state_nxt   = state;
      grant_cpld  = 1'b0;
      grant_req   = 1'b0;
      case (state)
         IDLE: begin
            if (s_cpld.tvalid && (!s_req.tvalid || (cpld_run < RUN_MAX))) begin
               grant_cpld = 1'b1;
            end else if (s_req.tvalid) begin
               grant_req = 1'b1;
            end
         end
         LOCK_CPLD: grant_cpld = 1'b1;
         LOCK_REQ:  grant_req  = 1'b1;
         default:   state_nxt  = IDLE;
      endcase

      accept_cpld = grant_cpld && s_cpld.tvalid && load;
      accept_req  = grant_req  && s_req.tvalid  && load;
      accept      = accept_cpld || accept_req;

      if (accept_cpld) begin
         state_nxt = s_cpld.tlast ? IDLE : LOCK_CPLD;
      end else if (accept_req) begin
         state_nxt = s_req.tlast ? IDLE : LOCK_REQ;
      end
   end

   assign s_cpld.tready = grant_cpld && load;
   assign s_req.tready  = grant_req  && load;

   always_comb begin
      beat_data = s_req.tdata;
      beat_keep = s_req.tkeep;
      beat_last = s_req.tlast;
      beat_user = s_req.tuser;
      if (grant_cpld) begin
         beat_data = s_cpld.tdata;
         beat_keep = s_cpld.tkeep;
         beat_last = s_cpld.tlast;
         beat_user = s_cpld.tuser;
      end
   end

   // Run length only moves on packet boundaries; a req packet resets the streak.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cpld_run <= '0;
      end else if (accept_cpld && s_cpld.tlast) begin
         if (cpld_run != RUN_MAX) begin
            cpld_run <= cpld_run + 1'b1;
         end
      end else if (accept_req && s_req.tlast) begin
         cpld_run <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m.tvalid <= 1'b0;
         m.tdata  <= '0;
         m.tkeep  <= '0;
         m.tlast  <= 1'b0;
         m.tuser  <= '0;
         m_src    <= 1'b0;
      end else if (accept) begin
         m.tvalid <= 1'b1;
         m.tdata  <= beat_data;
         m.tkeep  <= beat_keep;
         m.tlast  <= beat_last;
         m.tuser  <= beat_user;
         m_src    <= grant_cpld;
      end else if (m.tready) begin
         m.tvalid <= 1'b0;
      end
   end
endmodule
